lenet_dispatch_ctrl: RTL and testbench

- Parametrised successor of the single-buffer LeNet start controller.
- Tracks NUM_BUF frame buffers, each with its own level-type data_ready.
- Round-robin arbitrates pending buffers onto one LeNet engine and issues a one-clock lenet_go with the selected buffer index.
- Returns a per-buffer release pulse when the engine finishes; sits between the ov7670 frame writers and the LeNet core.

---
 rtl/lenet_dispatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_lenet_dispatch_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_dispatch_ctrl.sv
// rtl/lenet_dispatch_ctrl.sv - round-robin dispatcher of NUM_BUF frame buffers onto one LeNet engine
// Optional start-ack timeout enabled by defining LENET_DISPATCH_TIMEOUT_EN
module lenet_dispatch_ctrl #(
    parameter int NUM_BUF     = 2,
    parameter int FCNT_W      = 8,
    parameter int ACK_TIMEOUT = 1024,
    localparam int IDX_W      = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BUF-1:0] data_ready,
    input  logic               lenet_ready,
    output logic               lenet_go,
    output logic [IDX_W-1:0]   go_buf,
    output logic [NUM_BUF-1:0] buf_release,
    output logic               busy,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               ack_timeout
);

    if (NUM_BUF < 1 || NUM_BUF > 16 || ACK_TIMEOUT < 1) begin : g_bad_params
        $error("lenet_dispatch_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {E_READY, E_ACK, E_BUSY} eng_state_t;
    typedef enum logic [1:0] {B_IDLE, B_PEND, B_ISSUED, B_DONE} buf_state_t;

    eng_state_t         eng_q, eng_d;
    buf_state_t         buf_q [NUM_BUF];
    buf_state_t         buf_d [NUM_BUF];
    logic [IDX_W-1:0]   rr_ptr, grant, rr_next;
    logic [NUM_BUF-1:0] pend, rel_d;
    logic               grant_vld, do_go, do_done, do_timeout;

`ifdef LENET_DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
`endif

    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_BUF; i++) pend[i] = (buf_q[i] == B_PEND);
    end

    // Lowest pending index overall, overridden by the lowest one at or after rr_ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (pend[i]) begin
                grant_vld = 1'b1;
                grant     = IDX_W'(i);
            end
        end
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (pend[i] && IDX_W'(i) >= rr_ptr) grant = IDX_W'(i);
        end
    end

    assign rr_next = (int'(grant) == NUM_BUF - 1) ? '0 : grant + 1'b1;

    always_comb begin
        eng_d      = eng_q;
        do_go      = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (eng_q)
            E_READY: begin
                if (grant_vld) begin
                    do_go = 1'b1;
                    eng_d = E_ACK;
                end
            end
            E_ACK: begin
                if (!lenet_ready) begin
                    eng_d = E_BUSY;
`ifdef LENET_DISPATCH_TIMEOUT_EN
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    eng_d      = E_READY;
`endif
                end
            end
            E_BUSY: begin
                if (lenet_ready) begin
                    do_done = 1'b1;
                    eng_d   = E_READY;
                end
            end
            default: eng_d = E_READY;
        endcase
    end

    always_comb begin
        rel_d = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            buf_d[i] = buf_q[i];
            rel_d[i] = do_done && (go_buf == IDX_W'(i));
            case (buf_q[i])
                B_IDLE:   if (data_ready[i]) buf_d[i] = B_PEND;
                B_PEND:   if (do_go && grant == IDX_W'(i)) buf_d[i] = B_ISSUED;
                B_ISSUED: begin
                    if (rel_d[i]) buf_d[i] = B_DONE;
                    else if (do_timeout && go_buf == IDX_W'(i)) buf_d[i] = B_PEND;
                end
                B_DONE:   if (!data_ready[i]) buf_d[i] = B_IDLE;
                default:  buf_d[i] = B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_q       <= E_READY;
            rr_ptr      <= '0;
            lenet_go    <= 1'b0;
            go_buf      <= '0;
            buf_release <= '0;
            frame_cnt   <= '0;
            for (int i = 0; i < NUM_BUF; i++) buf_q[i] <= B_IDLE;
        end else begin
            eng_q       <= eng_d;
            lenet_go    <= do_go;
            buf_release <= rel_d;
            for (int i = 0; i < NUM_BUF; i++) buf_q[i] <= buf_d[i];
            if (do_go) begin
                go_buf    <= grant;
                rr_ptr    <= rr_next;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign busy = (eng_q != E_READY);

`ifdef LENET_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            ack_timeout <= 1'b0;
        end else begin
            ack_timeout <= do_timeout;
            if (eng_q == E_ACK && eng_d == E_ACK) to_cnt <= to_cnt + 1'b1;
            else to_cnt <= '0;
        end
    end
`else
    assign ack_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lenet_dispatch_ctrl.sv
// tb/tb_lenet_dispatch_ctrl.sv - directed self-checking bench for lenet_dispatch_ctrl (NUM_BUF=2)
module tb_lenet_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] data_ready;
    logic       lenet_ready;
    logic       lenet_go;
    logic [0:0] go_buf;
    logic [1:0] buf_release;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       ack_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lenet_dispatch_ctrl #(
        .NUM_BUF    (2),
        .FCNT_W     (8),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ready (data_ready),
        .lenet_ready(lenet_ready),
        .lenet_go   (lenet_go),
        .go_buf     (go_buf),
        .buf_release(buf_release),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .ack_timeout(ack_timeout)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        data_ready  = 2'b00;
        lenet_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_go(input int limit, output int lat, output logic [0:0] b, output logic [7:0] c);
        lat = -1;
        b   = 'x;
        c   = 'x;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (lenet_go === 1'b1) begin
                lat = n;
                b   = go_buf;
                c   = frame_cnt;
                break;
            end
        end
    endtask

    // Acks the go, keeps the engine running busy_cyc cycles, then completes it.
    task automatic engine_cycle(input int busy_cyc, output logic [1:0] rel, output int n_rel);
        rel   = 2'b00;
        n_rel = 0;
        lenet_ready = 1'b0;
        for (int n = 0; n < busy_cyc; n++) begin
            tick();
            if (buf_release !== 2'b00) begin rel |= buf_release; n_rel++; end
        end
        lenet_ready = 1'b1;
        tick();
        if (buf_release !== 2'b00) begin rel |= buf_release; n_rel++; end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        data_ready  = 2'b00;
        lenet_ready = 1'b1;
        tick();
        total++;
        if ({lenet_go, go_buf, buf_release, busy, frame_cnt, ack_timeout} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs: got go=%b buf=%b rel=%b busy=%b cnt=%0d to=%b want all 0",
                     lenet_go, go_buf, buf_release, busy, frame_cnt, ack_timeout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] rel;
        int n_rel;
        do_reset();
        data_ready = 2'b01;
        tick();
        total++;
        if (lenet_go !== 1'b0) begin bad++; $display("FAIL single_early_go: got %b want 0", lenet_go); end
        tick();
        total++;
        if (lenet_go !== 1'b1) begin bad++; $display("FAIL single_go: got %b want 1", lenet_go); end
        total++;
        if (go_buf !== 1'b0) begin bad++; $display("FAIL single_go_buf: got %0d want 0", go_buf); end
        total++;
        if (frame_cnt !== 8'd1) begin bad++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        engine_cycle(10, rel, n_rel);
        total++;
        if (rel !== 2'b01 || n_rel != 1) begin
            bad++; $display("FAIL single_release: got %b x%0d want 01 x1", rel, n_rel);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy); end
        tick();
        total++;
        if ({lenet_go, buf_release, busy} !== 4'b0) begin
            bad++; $display("FAIL single_quiet: got go=%b rel=%b busy=%b want 0", lenet_go, buf_release, busy);
        end
        data_ready = 2'b00;
        tick();
    endtask

    task automatic test_both_pending();
        logic [1:0] rel;
        int n_rel, lat, gos;
        logic [0:0] b;
        logic [7:0] c;
        do_reset();
        data_ready = 2'b11;
        wait_go(4, lat, b, c);
        total++;
        if (lat != 2 || b !== 1'b0 || c !== 8'd1) begin
            bad++; $display("FAIL both_first: got lat=%0d buf=%0d cnt=%0d want 2/0/1", lat, b, c);
        end
        engine_cycle(3, rel, n_rel);
        total++;
        if (rel !== 2'b01 || n_rel != 1) begin bad++; $display("FAIL both_rel0: got %b x%0d want 01 x1", rel, n_rel); end
        wait_go(4, lat, b, c);
        total++;
        if (lat != 1 || b !== 1'b1 || c !== 8'd2) begin
            bad++; $display("FAIL both_second: got lat=%0d buf=%0d cnt=%0d want 1/1/2", lat, b, c);
        end
        engine_cycle(3, rel, n_rel);
        total++;
        if (rel !== 2'b10 || n_rel != 1) begin bad++; $display("FAIL both_rel1: got %b x%0d want 10 x1", rel, n_rel); end
        gos = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (lenet_go === 1'b1 || buf_release !== 2'b00) gos++;
        end
        total++;
        if (gos != 0) begin bad++; $display("FAIL both_extra_activity: got %0d want 0", gos); end
        data_ready = 2'b00;
        tick();
    endtask

    task automatic test_rr_wrap();
        logic [1:0] rel;
        int n_rel, lat;
        logic [0:0] b;
        logic [7:0] c;
        do_reset();
        data_ready = 2'b01;
        wait_go(4, lat, b, c);
        engine_cycle(2, rel, n_rel);
        data_ready = 2'b00;
        tick();
        data_ready = 2'b11;
        wait_go(4, lat, b, c);
        total++;
        if (lat != 2 || b !== 1'b1) begin bad++; $display("FAIL rr_after0: got lat=%0d buf=%0d want 2/1", lat, b); end
        engine_cycle(2, rel, n_rel);
        wait_go(4, lat, b, c);
        total++;
        if (lat != 1 || b !== 1'b0 || c !== 8'd3) begin
            bad++; $display("FAIL rr_next0: got lat=%0d buf=%0d cnt=%0d want 1/0/3", lat, b, c);
        end
        engine_cycle(2, rel, n_rel);
        data_ready = 2'b00;
        tick();
        data_ready = 2'b10;
        wait_go(4, lat, b, c);
        engine_cycle(2, rel, n_rel);
        total++;
        if (rel !== 2'b10) begin bad++; $display("FAIL rr_serve1: got %b want 10", rel); end
        data_ready = 2'b00;
        tick();
        data_ready = 2'b11;
        wait_go(4, lat, b, c);
        total++;
        if (lat != 2 || b !== 1'b0) begin bad++; $display("FAIL rr_wrap: got lat=%0d buf=%0d want 2/0", lat, b); end
        engine_cycle(2, rel, n_rel);
        wait_go(4, lat, b, c);
        engine_cycle(2, rel, n_rel);
        data_ready = 2'b00;
        tick();
    endtask

    task automatic test_hold_high();
        logic [1:0] rel;
        int n_rel, lat, gos;
        logic [0:0] b;
        logic [7:0] c;
        do_reset();
        data_ready = 2'b01;
        wait_go(4, lat, b, c);
        engine_cycle(4, rel, n_rel);
        gos = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (lenet_go === 1'b1) gos++;
        end
        total++;
        if (gos != 0) begin bad++; $display("FAIL hold_no_rego: got %0d gos want 0", gos); end
        data_ready = 2'b00;
        tick();
        data_ready = 2'b01;
        wait_go(4, lat, b, c);
        total++;
        if (lat != 2 || b !== 1'b0 || c !== 8'd2) begin
            bad++; $display("FAIL hold_rearm: got lat=%0d buf=%0d cnt=%0d want 2/0/2", lat, b, c);
        end
        engine_cycle(2, rel, n_rel);
        data_ready = 2'b00;
        tick();
    endtask

    task automatic test_reset_in_busy();
        int lat, rels;
        logic [0:0] b;
        logic [7:0] c;
        do_reset();
        data_ready = 2'b01;
        wait_go(4, lat, b, c);
        lenet_ready = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rb_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({lenet_go, buf_release, busy, frame_cnt} !== 12'd0) begin
            bad++; $display("FAIL rb_async_clear: got go=%b rel=%b busy=%b cnt=%0d want 0",
                            lenet_go, buf_release, busy, frame_cnt);
        end
        data_ready  = 2'b11;
        lenet_ready = 1'b1;
        rels = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (buf_release !== 2'b00) rels++;
        end
        rst_n = 1'b1;
        wait_go(4, lat, b, c);
        if (buf_release !== 2'b00) rels++;
        total++;
        if (rels != 0) begin bad++; $display("FAIL rb_no_release: got %0d want 0", rels); end
        total++;
        if (lat != 2 || b !== 1'b0 || c !== 8'd1) begin
            bad++; $display("FAIL rb_redispatch: got lat=%0d buf=%0d cnt=%0d want 2/0/1", lat, b, c);
        end
    endtask

`ifdef LENET_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0] rel;
        int n_rel, lat, seen;
        logic [0:0] b;
        logic [7:0] c;
        do_reset();
        data_ready = 2'b01;
        wait_go(4, lat, b, c);
        seen = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ack_timeout === 1'b1) begin seen = n; break; end
        end
        total++;
        if (seen != 16) begin bad++; $display("FAIL to_pulse_at: got %0d want 16", seen); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b want 0", busy); end
        tick();
        total++;
        if (lenet_go !== 1'b1 || go_buf !== 1'b0 || frame_cnt !== 8'd2 || ack_timeout !== 1'b0) begin
            bad++; $display("FAIL to_reissue: got go=%b buf=%0d cnt=%0d to=%b want 1/0/2/0",
                            lenet_go, go_buf, frame_cnt, ack_timeout);
        end
        engine_cycle(2, rel, n_rel);
        total++;
        if (rel !== 2'b01 || n_rel != 1) begin bad++; $display("FAIL to_release: got %b x%0d want 01 x1", rel, n_rel); end
        data_ready = 2'b00;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        logic [1:0] rel;
        int n_rel, lat, pulses;
        logic [0:0] b;
        logic [7:0] c;
        do_reset();
        data_ready = 2'b01;
        wait_go(4, lat, b, c);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (ack_timeout !== 1'b0 || lenet_go !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0 || busy !== 1'b1) begin
            bad++; $display("FAIL noto_wait: got pulses=%0d busy=%b want 0/1", pulses, busy);
        end
        engine_cycle(2, rel, n_rel);
        total++;
        if (rel !== 2'b01) begin bad++; $display("FAIL noto_release: got %b want 01", rel); end
        data_ready = 2'b00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_both_pending();
        test_rr_wrap();
        test_hold_high();
        test_reset_in_busy();
`ifdef LENET_DISPATCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
